// File: rtl/circular_lane_buffer.sv
// circular_lane_buffer
//   LANES x DEPTH word store. A single write port loads it one word at a time.
//   A read sequencer returns one entry from every lane in parallel on each
//   accepted read_en. It walks entries 0..len-1 and then either wraps
//   (circular mode) or stops in DONE (one-shot mode).
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous active-low reset (control, pointer, outputs; not storage)
//   wr_en        write strobe; mem[wr_lane][wr_addr] <= wr_data
//   wr_lane      write target lane
//   wr_addr      write target entry
//   wr_data      write data
//   cfg_len      ring length, latched on start (0 or > DEPTH means DEPTH)
//   cfg_oneshot  mode, latched on start (0 circular, 1 one pass)
//   start        begin/restart a read sequence (beats stop and read_en)
//   stop         abort the sequence and return to IDLE
//   read_en      request one read access while running
//   read_data    registered lane words, lane k at [k*DATA_W +: DATA_W]
//   rd_valid     one-cycle pulse: read_data is new
//   rd_last      with rd_valid: the word came from entry len-1
//   read_ptr     entry the next read will access
//   busy         sequencer in RUN
//   done         sequencer in DONE
module circular_lane_buffer #(
    parameter int DATA_W = 16,
    parameter int LANES  = 8,
    parameter int DEPTH  = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [LW-1:0]           wr_lane,
    input  logic [AW-1:0]           wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic [AW:0]             cfg_len,
    input  logic                    cfg_oneshot,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    read_en,
    output logic [LANES*DATA_W-1:0] read_data,
    output logic                    rd_valid,
    output logic                    rd_last,
    output logic [AW-1:0]           read_ptr,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [AW:0] LEN_FULL = DEPTH[AW:0];
    localparam logic [AW:0] LEN_ONE  = 1;

    // Out-of-range lengths fold to the full ring.
    function automatic logic [AW:0] clamp_len(input logic [AW:0] l);
        if ((l == '0) || (l > LEN_FULL)) begin
            return LEN_FULL;
        end
        return l;
    endfunction

    logic [DATA_W-1:0] mem [LANES][DEPTH];

    state_t        state, state_nxt;
    logic [AW-1:0] ptr_nxt;
    logic [AW:0]   len_q, len_nxt;
    logic          oneshot_q, oneshot_nxt;
    logic          rd_fire_p0;
    logic          at_last_p0;

    assign at_last_p0 = ({1'b0, read_ptr} == (len_q - LEN_ONE));

    // Storage has no reset so a reset mid-run leaves the loaded data intact.
    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_lane) < LANES)) begin
            mem[wr_lane][wr_addr] <= wr_data;
        end
    end

    // Next-state decode: start beats stop, stop beats a read.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = read_ptr;
        len_nxt     = len_q;
        oneshot_nxt = oneshot_q;
        rd_fire_p0  = 1'b0;
        if (start) begin
            state_nxt   = RUN;
            ptr_nxt     = '0;
            len_nxt     = clamp_len(cfg_len);
            oneshot_nxt = cfg_oneshot;
        end else if (stop) begin
            state_nxt = IDLE;
        end else if ((state == RUN) && read_en) begin
            rd_fire_p0 = 1'b1;
            if (at_last_p0) begin
                ptr_nxt = '0;
                if (oneshot_q) begin
                    state_nxt = DONE;
                end
            end else begin
                ptr_nxt = read_ptr + 1'b1;
            end
        end
    end

    // Stage p0 -> p1: the read registers mem[*][read_ptr] as it was before
    // any same-edge write, so a colliding write is seen on the next pass.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            read_ptr  <= '0;
            len_q     <= LEN_FULL;
            oneshot_q <= 1'b0;
            read_data <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
        end else begin
            state     <= state_nxt;
            read_ptr  <= ptr_nxt;
            len_q     <= len_nxt;
            oneshot_q <= oneshot_nxt;
            rd_valid  <= rd_fire_p0;
            rd_last   <= rd_fire_p0 && at_last_p0;
            if (rd_fire_p0) begin
                for (int k = 0; k < LANES; k++) begin
                    read_data[k*DATA_W +: DATA_W] <= mem[k][read_ptr];
                end
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_circular_lane_buffer.sv
module tb_circular_lane_buffer;

    localparam int DATA_W = 16;
    localparam int LANES  = 8;
    localparam int DEPTH  = 8;
    localparam int AW     = $clog2(DEPTH);
    localparam int LW     = $clog2(LANES);
    localparam int WW     = LANES * DATA_W;

    typedef logic [WW-1:0] wide_t;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [LW-1:0]     wr_lane;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [AW:0]       cfg_len;
    logic              cfg_oneshot;
    logic              start;
    logic              stop;
    logic              read_en;
    wide_t             read_data;
    logic              rd_valid;
    logic              rd_last;
    logic [AW-1:0]     read_ptr;
    logic              busy;
    logic              done;

    circular_lane_buffer #(
        .DATA_W(DATA_W),
        .LANES (LANES),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_lane    (wr_lane),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cfg_len    (cfg_len),
        .cfg_oneshot(cfg_oneshot),
        .start      (start),
        .stop       (stop),
        .read_en    (read_en),
        .read_data  (read_data),
        .rd_valid   (rd_valid),
        .rd_last    (rd_last),
        .read_ptr   (read_ptr),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: sequencer described by running flag, integer pointer,
    // and modular arithmetic over the latched length.
    logic [DATA_W-1:0] m_mem [LANES][DEPTH];
    bit    m_run, m_done, m_os, m_valid, m_last;
    int    m_ptr, m_len;
    wide_t m_data;

    task automatic model_reset();
        m_run = 0; m_done = 0; m_os = 0; m_valid = 0; m_last = 0;
        m_ptr = 0; m_len = DEPTH; m_data = '0;
    endtask

    task automatic model_clock();
        m_valid = 0;
        m_last  = 0;
        if (start) begin
            m_run  = 1;
            m_done = 0;
            m_ptr  = 0;
            m_len  = (cfg_len == 0 || int'(cfg_len) > DEPTH) ? DEPTH : int'(cfg_len);
            m_os   = cfg_oneshot;
        end else if (stop) begin
            m_run  = 0;
            m_done = 0;
        end else if (m_run && read_en) begin
            for (int k = 0; k < LANES; k++) m_data[k*DATA_W +: DATA_W] = m_mem[k][m_ptr];
            m_valid = 1;
            m_last  = (m_ptr == m_len - 1);
            if (m_last && m_os) begin
                m_run  = 0;
                m_done = 1;
            end
            m_ptr = (m_ptr + 1) % m_len;
        end
        if (wr_en) m_mem[wr_lane][wr_addr] = wr_data;
    endtask

    task automatic check(input string name, input wide_t got, input wide_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    task automatic compare_all();
        check("rd_valid", wide_t'(rd_valid), wide_t'(m_valid));
        check("rd_last", wide_t'(rd_last), wide_t'(m_last));
        check("read_ptr", wide_t'(read_ptr), wide_t'(m_ptr));
        check("busy", wide_t'(busy), wide_t'(m_run));
        check("done", wide_t'(done), wide_t'(m_done));
        check("read_data", read_data, m_data);
    endtask

    task automatic step();
        model_clock();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_lane = '0; wr_addr = '0; wr_data = '0;
        cfg_len = '0; cfg_oneshot = 0; start = 0; stop = 0; read_en = 0;
    endtask

    function automatic wide_t pat(input int e);
        wide_t w;
        for (int k = 0; k < LANES; k++) w[k*DATA_W +: DATA_W] = DATA_W'((k << 8) | e);
        return w;
    endfunction

    typedef struct {
        logic        start;
        logic        stop;
        logic        rd;
        logic [AW:0] len;
        logic        os;
        logic        v;
        logic        l;
        int          ptr;
        logic        busy;
        logic        done;
        int          entry;
    } vec_t;

    vec_t vt [17];

    initial begin
        // start stop rd len os | v l ptr busy done entry
        vt = '{
            '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, -1},
            '{0, 0, 1, 3, 1, 1, 0, 1, 1, 0, 0},
            '{0, 0, 1, 3, 1, 1, 0, 2, 1, 0, 1},
            '{0, 0, 1, 3, 1, 1, 0, 3, 1, 0, 2},
            '{0, 0, 1, 3, 1, 1, 0, 4, 1, 0, 3},
            '{0, 0, 1, 3, 1, 1, 0, 5, 1, 0, 4},
            '{0, 0, 1, 3, 1, 1, 0, 6, 1, 0, 5},
            '{0, 0, 1, 3, 1, 1, 0, 7, 1, 0, 6},
            '{0, 0, 1, 3, 1, 1, 1, 0, 1, 0, 7},
            '{0, 0, 1, 3, 1, 1, 0, 1, 1, 0, 0},
            '{0, 0, 1, 3, 1, 1, 0, 2, 1, 0, 1},
            '{1, 0, 0, 3, 1, 0, 0, 0, 1, 0, -1},
            '{0, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0},
            '{0, 0, 1, 0, 0, 1, 0, 2, 1, 0, 1},
            '{0, 0, 1, 0, 0, 1, 1, 0, 0, 1, 2},
            '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1, -1},
            '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1, -1}
        };

        // Reset state
        idle_inputs();
        rst = 0;
        model_reset();
        #3;
        compare_all();
        #9 rst = 1;

        // Preload mem[k][a] = k<<8 | a
        for (int k = 0; k < LANES; k++) begin
            for (int a = 0; a < DEPTH; a++) begin
                wr_en = 1; wr_lane = LW'(k); wr_addr = AW'(a); wr_data = DATA_W'((k << 8) | a);
                step();
            end
        end
        idle_inputs();

        // Circular full ring, then one-shot len 3
        for (int i = 0; i < 17; i++) begin
            start = vt[i].start; stop = vt[i].stop; read_en = vt[i].rd;
            cfg_len = vt[i].len; cfg_oneshot = vt[i].os;
            step();
            check($sformatf("vec%0d_valid", i), wide_t'(rd_valid), wide_t'(vt[i].v));
            check($sformatf("vec%0d_last", i), wide_t'(rd_last), wide_t'(vt[i].l));
            check($sformatf("vec%0d_ptr", i), wide_t'(read_ptr), wide_t'(vt[i].ptr));
            check($sformatf("vec%0d_busy", i), wide_t'(busy), wide_t'(vt[i].busy));
            check($sformatf("vec%0d_done", i), wide_t'(done), wide_t'(vt[i].done));
            if (vt[i].entry >= 0) check($sformatf("vec%0d_data", i), read_data, pat(vt[i].entry));
        end
        idle_inputs();

        // Start and read_en together: start wins
        start = 1; cfg_len = 5; step(); start = 0;
        read_en = 1; step(); step();
        start = 1; step();
        check("restart_no_read", wide_t'(rd_valid), wide_t'(0));
        check("restart_ptr", wide_t'(read_ptr), wide_t'(0));
        start = 0; step();
        check("restart_first", read_data, pat(0));
        idle_inputs();

        // Write collides with the entry being read
        start = 1; cfg_len = 4; step(); start = 0;
        read_en = 1; step(); step();
        wr_en = 1; wr_lane = 3; wr_addr = 2; wr_data = 16'hBEEF;
        step();
        check("collide_old", wide_t'(read_data[3*DATA_W +: DATA_W]), wide_t'(16'h0302));
        wr_en = 0;
        step(); step(); step(); step();
        check("collide_new", wide_t'(read_data[3*DATA_W +: DATA_W]), wide_t'(16'hBEEF));
        idle_inputs();

        // Asynchronous reset mid-run
        start = 1; step(); start = 0;
        read_en = 1; step(); step(); step();
        #3 rst = 0;
        model_reset();
        #1;
        compare_all();
        read_en = 0;
        @(posedge clk); #1;
        compare_all();
        #2 rst = 1;
        start = 1; step(); start = 0;
        read_en = 1; step();
        check("post_reset_entry0", read_data, pat(0));
        idle_inputs();

        // read_en in IDLE, then stop during RUN
        stop = 1; step(); stop = 0;
        read_en = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_read_valid", wide_t'(rd_valid), wide_t'(0));
        end
        read_en = 0;
        start = 1; step(); start = 0;
        read_en = 1; step(); step();
        read_en = 0; stop = 1; step(); stop = 0;
        check("stop_busy", wide_t'(busy), wide_t'(0));
        check("stop_ptr", wide_t'(read_ptr), wide_t'(2));
        read_en = 1; step(); step();
        check("stop_ptr_frozen", wide_t'(read_ptr), wide_t'(2));
        check("stop_no_valid", wide_t'(rd_valid), wide_t'(0));
        idle_inputs();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            start       = ($urandom_range(0, 19) == 0);
            stop        = ($urandom_range(0, 39) == 0);
            read_en     = ($urandom_range(0, 2) != 0);
            wr_en       = ($urandom_range(0, 1) == 1);
            wr_lane     = LW'($urandom);
            wr_addr     = AW'($urandom);
            wr_data     = DATA_W'($urandom);
            cfg_len     = (AW + 1)'($urandom);
            cfg_oneshot = ($urandom_range(0, 1) == 1);
            step();
        end
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
